// File: rtl/mesm6_mem_arbiter.sv
// Arbitrates one single-ported memory between the MESM-6 instruction and data buses.
// A sampled request set is served data-first, then fetch, and both dones pulse together.
module mesm6_mem_arbiter #(
  parameter int unsigned ADDR_W  = 15,
  parameter int unsigned DATA_W  = 48,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ibus_fetch,
  input  logic [ADDR_W-1:0] ibus_addr,
  output logic [DATA_W-1:0] ibus_input,
  output logic              ibus_done,
  input  logic              dbus_read,
  input  logic              dbus_write,
  input  logic [ADDR_W-1:0] dbus_addr,
  input  logic [DATA_W-1:0] dbus_output,
  output logic [DATA_W-1:0] dbus_input,
  output logic              dbus_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              bus_error
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  logic               pend_d;
  logic               pend_i;
  logic               err;
  logic [ADDR_W-1:0]  i_addr;
  logic [CNT_W-1:0]   tcnt;
  logic               timed_out;
  logic               access_end;

  // The timeout fires on the cycle that would push the count to TIMEOUT; a coincident ack wins.
  always_comb begin
    timed_out  = 1'b0;
    if (TIMEOUT != 0)
      timed_out = mem_req && !mem_ack && (tcnt == CNT_LAST);
    access_end = (mem_req && mem_ack) || timed_out;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      pend_d     <= 1'b0;
      pend_i     <= 1'b0;
      err        <= 1'b0;
      i_addr     <= '0;
      tcnt       <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      ibus_input <= '0;
      dbus_input <= '0;
      ibus_done  <= 1'b0;
      dbus_done  <= 1'b0;
      bus_error  <= 1'b0;
    end else begin
      ibus_done <= 1'b0;
      dbus_done <= 1'b0;
      bus_error <= 1'b0;
      case (state)
        IDLE: begin
          pend_d <= dbus_read | dbus_write;
          pend_i <= ibus_fetch;
          i_addr <= ibus_addr;
          err    <= 1'b0;
          tcnt   <= '0;
          if (dbus_read || dbus_write) begin
            state     <= DATA;
            mem_req   <= 1'b1;
            mem_we    <= dbus_write;
            mem_addr  <= dbus_addr;
            mem_wdata <= dbus_output;
          end else if (ibus_fetch) begin
            state    <= FETCH;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= ibus_addr;
          end
        end
        DATA: begin
          if (access_end) begin
            if (!mem_we)
              dbus_input <= mem_ack ? mem_rdata : '0;
            if (!mem_ack)
              err <= 1'b1;
            tcnt <= '0;
            // A pending fetch keeps mem_req high and simply swaps in the fetch address.
            if (pend_i) begin
              state    <= FETCH;
              mem_we   <= 1'b0;
              mem_addr <= i_addr;
            end else begin
              state     <= DONE;
              mem_req   <= 1'b0;
              mem_we    <= 1'b0;
              dbus_done <= pend_d;
              bus_error <= err | !mem_ack;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        FETCH: begin
          if (access_end) begin
            ibus_input <= mem_ack ? mem_rdata : '0;
            if (!mem_ack)
              err <= 1'b1;
            tcnt      <= '0;
            state     <= DONE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            ibus_done <= pend_i;
            dbus_done <= pend_d;
            bus_error <= err | !mem_ack;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mesm6_mem_arbiter.sv
// Directed bench for mesm6_mem_arbiter, built with TIMEOUT=4 so the timeout path is reachable.
module tb_mesm6_mem_arbiter;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 48;

  logic              clk;
  logic              reset_n;
  logic              ibus_fetch;
  logic [ADDR_W-1:0] ibus_addr;
  logic [DATA_W-1:0] ibus_input;
  logic              ibus_done;
  logic              dbus_read;
  logic              dbus_write;
  logic [ADDR_W-1:0] dbus_addr;
  logic [DATA_W-1:0] dbus_output;
  logic [DATA_W-1:0] dbus_input;
  logic              dbus_done;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              bus_error;

  int total;
  int bad;

  mesm6_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .ibus_fetch(ibus_fetch), .ibus_addr(ibus_addr), .ibus_input(ibus_input), .ibus_done(ibus_done),
    .dbus_read(dbus_read), .dbus_write(dbus_write), .dbus_addr(dbus_addr),
    .dbus_output(dbus_output), .dbus_input(dbus_input), .dbus_done(dbus_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_error(bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [163:0] outs;
    reset_n = 1'b0; mem_ack = 1'b1; ibus_fetch = 1'b1; dbus_read = 1'b1; dbus_write = 1'b1;
    ibus_addr = 15'h1234; dbus_addr = 15'h4321; dbus_output = 48'hDEAD_BEEF_0001; mem_rdata = 48'h1111_2222_3333;
    for (int i = 0; i < 2; i++) begin
      tick();
      outs = {mem_req, mem_we, mem_addr, mem_wdata, ibus_done, dbus_done, bus_error, ibus_input, dbus_input};
      total++;
      if (outs !== '0) begin
        bad++;
        $display("FAIL reset_outputs cycle %0d: got %h want 0", i, outs);
      end
    end
    ibus_fetch = 1'b0; dbus_read = 1'b0; dbus_write = 1'b0; mem_ack = 1'b0;
    reset_n = 1'b1;
    tick();
    total++;
    if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_idle_req: got %b want 0", mem_req); end
  endtask

  task automatic test_fetch();
    ibus_fetch = 1'b1; ibus_addr = 15'h0100; mem_rdata = 48'h1234_5678_9ABC;
    tick();
    total++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 15'h0100}) begin
      bad++; $display("FAIL fetch_req: got req=%b we=%b addr=%h want 1 0 0100", mem_req, mem_we, mem_addr);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0; ibus_fetch = 1'b0;
    total++;
    if ({ibus_done, dbus_done, bus_error, mem_req} !== 4'b1000) begin
      bad++; $display("FAIL fetch_done: got idone=%b ddone=%b err=%b req=%b want 1 0 0 0",
                      ibus_done, dbus_done, bus_error, mem_req);
    end
    total++;
    if (ibus_input !== 48'h1234_5678_9ABC) begin
      bad++; $display("FAIL fetch_data: got %h want 123456789abc", ibus_input);
    end
    tick();
    total++;
    if (ibus_done !== 1'b0) begin bad++; $display("FAIL fetch_pulse: got %b want 0", ibus_done); end
    tick();
  endtask

  task automatic test_read();
    dbus_read = 1'b1; dbus_addr = 15'h0055; mem_rdata = 48'hA5A5_5A5A_C3C3;
    tick();
    total++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 15'h0055}) begin
      bad++; $display("FAIL read_req: got req=%b we=%b addr=%h want 1 0 0055", mem_req, mem_we, mem_addr);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0; dbus_read = 1'b0;
    total++;
    if ({dbus_done, ibus_done, dbus_input} !== {1'b1, 1'b0, 48'hA5A5_5A5A_C3C3}) begin
      bad++; $display("FAIL read_done: got ddone=%b idone=%b data=%h want 1 0 a5a55a5ac3c3",
                      dbus_done, ibus_done, dbus_input);
    end
    tick();
    tick();
  endtask

  // Write ack arrives in the 4th mem_req cycle, the same cycle the timeout would fire.
  task automatic test_write_then_fetch();
    dbus_write = 1'b1; dbus_addr = 15'h7FFF; dbus_output = 48'hFFFF_FFFF_FFFF;
    ibus_fetch = 1'b1; ibus_addr = 15'h0002; mem_rdata = 48'h0BAD_F00D_0042;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, ibus_done, dbus_done} !==
          {1'b1, 1'b1, 15'h7FFF, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b0}) begin
        bad++; $display("FAIL write_phase %0d: got req=%b we=%b addr=%h wd=%h id=%b dd=%b want 1 1 7fff ffffffffffff 0 0",
                        i, mem_req, mem_we, mem_addr, mem_wdata, ibus_done, dbus_done);
      end
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ack = 1'b1;
      total++;
      if ({mem_req, mem_we, mem_addr, ibus_done, dbus_done} !== {1'b1, 1'b0, 15'h0002, 1'b0, 1'b0}) begin
        bad++; $display("FAIL fetch_phase %0d: got req=%b we=%b addr=%h id=%b dd=%b want 1 0 0002 0 0",
                        i, mem_req, mem_we, mem_addr, ibus_done, dbus_done);
      end
      tick();
    end
    mem_ack = 1'b0; dbus_write = 1'b0; ibus_fetch = 1'b0;
    total++;
    if ({ibus_done, dbus_done, bus_error, mem_req} !== 4'b1100) begin
      bad++; $display("FAIL both_done: got id=%b dd=%b err=%b req=%b want 1 1 0 0",
                      ibus_done, dbus_done, bus_error, mem_req);
    end
    total++;
    if ({ibus_input, dbus_input} !== {48'h0BAD_F00D_0042, 48'hA5A5_5A5A_C3C3}) begin
      bad++; $display("FAIL both_data: got i=%h d=%h want 0badf00d0042 a5a55a5ac3c3", ibus_input, dbus_input);
    end
    tick();
    tick();
  endtask

  task automatic test_timeout();
    int req_cycles;
    int done_seen;
    req_cycles = 0; done_seen = 0;
    dbus_read = 1'b1; dbus_addr = 15'h0777; mem_ack = 1'b0;
    for (int i = 0; i < 20 && done_seen == 0; i++) begin
      tick();
      if (mem_req) req_cycles++;
      if (dbus_done) begin
        done_seen = 1;
        dbus_read = 1'b0;
        total++;
        if ({bus_error, dbus_input} !== {1'b1, 48'h0}) begin
          bad++; $display("FAIL timeout_done: got err=%b data=%h want 1 0", bus_error, dbus_input);
        end
      end
    end
    total++;
    if (done_seen != 1) begin bad++; $display("FAIL timeout_wait: got no dbus_done want done within 20 cycles"); end
    total++;
    if (req_cycles != 4) begin bad++; $display("FAIL timeout_req_len: got %0d want 4", req_cycles); end
    tick();
    total++;
    if ({bus_error, dbus_done, mem_req} !== 3'b000) begin
      bad++; $display("FAIL timeout_after: got err=%b dd=%b req=%b want 0 0 0", bus_error, dbus_done, mem_req);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    ibus_fetch = 1'b1; ibus_addr = 15'h0010; mem_rdata = 48'h0000_0000_1111;
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0; ibus_addr = 15'h0020; mem_rdata = 48'h0000_0000_2222;
    total++;
    if ({ibus_done, ibus_input} !== {1'b1, 48'h0000_0000_1111}) begin
      bad++; $display("FAIL b2b_first: got done=%b data=%h want 1 000000001111", ibus_done, ibus_input);
    end
    tick();
    total++;
    if ({mem_req, ibus_done} !== 2'b00) begin
      bad++; $display("FAIL b2b_idle: got req=%b done=%b want 0 0", mem_req, ibus_done);
    end
    tick();
    total++;
    if ({mem_req, mem_addr} !== {1'b1, 15'h0020}) begin
      bad++; $display("FAIL b2b_second_req: got req=%b addr=%h want 1 0020", mem_req, mem_addr);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0; ibus_fetch = 1'b0;
    total++;
    if ({ibus_done, ibus_input} !== {1'b1, 48'h0000_0000_2222}) begin
      bad++; $display("FAIL b2b_second: got done=%b data=%h want 1 000000002222", ibus_done, ibus_input);
    end
    tick();
    tick();
    total++;
    if ({mem_req, ibus_done} !== 2'b00) begin
      bad++; $display("FAIL b2b_no_dup: got req=%b done=%b want 0 0", mem_req, ibus_done);
    end
  endtask

  task automatic test_reset_mid();
    ibus_fetch = 1'b1; ibus_addr = 15'h0033; mem_rdata = 48'h5555_6666_7777;
    tick();
    total++;
    if (mem_req !== 1'b1) begin bad++; $display("FAIL mid_req: got %b want 1", mem_req); end
    ibus_fetch = 1'b0; reset_n = 1'b0;
    tick();
    total++;
    if ({mem_req, ibus_input} !== {1'b0, 48'h0}) begin
      bad++; $display("FAIL mid_reset: got req=%b data=%h want 0 0", mem_req, ibus_input);
    end
    reset_n = 1'b1; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    total++;
    if ({ibus_done, dbus_done, mem_req, ibus_input} !== {3'b000, 48'h0}) begin
      bad++; $display("FAIL mid_late_ack: got id=%b dd=%b req=%b data=%h want 0 0 0 0",
                      ibus_done, dbus_done, mem_req, ibus_input);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    reset_n = 1'b0; ibus_fetch = 1'b0; dbus_read = 1'b0; dbus_write = 1'b0; mem_ack = 1'b0;
    ibus_addr = '0; dbus_addr = '0; dbus_output = '0; mem_rdata = '0;
    test_reset();
    test_fetch();
    test_read();
    test_write_then_fetch();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
